// File: rtl/uart_pkg.sv
// Shared definitions for the UART stream blocks: FSM states, parity modes and
// the parity helper.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Upper bits must be zero when the data width is below 9.
  function automatic logic parity_bit(input logic [8:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_tx_stream_if.sv
// Valid/ready byte stream into the UART transmitter.
interface uart_tx_stream_if #(parameter int DATA_BITS = 8);

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_tx_stream_fifo.sv
// Synchronous FIFO with level output and a registered full flag; shared with
// the receive path.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_wdata,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_full;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [LW-1:0]    w_level_next;

  // A pop in the same cycle never frees room for a push while full.
  assign w_push_ok = i_push && !r_full;
  assign w_pop_ok  = i_pop && (r_level != '0);

  always_comb begin
    w_level_next = r_level;
    if (w_push_ok && !w_pop_ok)
      w_level_next = r_level + 1'b1;
    else if (!w_push_ok && w_pop_ok)
      w_level_next = r_level - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= w_level_next;
      r_full  <= (w_level_next == LW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

endmodule

// File: rtl/uart_tx_stream.sv
// FIFO-buffered UART transmitter: configurable data width, parity and stop
// bits, LSB first, back-to-back frames while words are queued.
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 234,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  uart_tx_stream_if.slave             s_tx,
  output logic                        uart_tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  state_t               r_state;
  state_t               w_state_next;
  logic [CW-1:0]        r_clk_cnt;
  logic [IW-1:0]        r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_tx;
  logic                 w_bit_done;
  logic                 w_pop;
  logic                 w_line;
  logic                 w_full;
  logic                 w_empty;
  logic [DATA_BITS-1:0] w_head;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (s_tx.tx_valid),
    .i_pop   (w_pop),
    .i_wdata (s_tx.tx_data),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  assign w_bit_done = (r_clk_cnt == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_line       = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = S_START;
        end
      end
      S_START: begin
        w_line = 1'b0;
        if (w_bit_done) w_state_next = S_DATA;
      end
      S_DATA: begin
        w_line = r_shift[0];
        if (w_bit_done && (r_bit_idx == IW'(DATA_BITS - 1)))
          w_state_next = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        w_line = r_par;
        if (w_bit_done) w_state_next = S_STOP;
      end
      S_STOP: begin
        if (w_bit_done && (r_bit_idx == IW'(STOP_BITS - 1))) begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_state_next = S_START;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // The line value is registered, so it trails the state by one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_tx      <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_tx    <= w_line;
      if ((r_state == S_IDLE) || w_bit_done)
        r_clk_cnt <= '0;
      else
        r_clk_cnt <= r_clk_cnt + 1'b1;
      if (w_state_next != r_state)
        r_bit_idx <= '0;
      else if (w_bit_done)
        r_bit_idx <= r_bit_idx + 1'b1;
      if (w_pop) begin
        r_shift <= w_head;
        r_par   <= parity_bit(9'(w_head), PARITY);
      end else if ((r_state == S_DATA) && w_bit_done) begin
        r_shift <= r_shift >> 1;
      end
    end
  end

  assign uart_tx       = r_tx;
  assign busy          = (r_state != S_IDLE) || !w_empty;
  assign s_tx.tx_ready = !w_full;

endmodule
